cpu_bus_master: RTL and testbench

- Parametrised bus interface unit between the CPU core sequencer and the external memory bus.
- Replaces the hard-wired single-transfer strobe logic embedded in the core.
- Splits one CPU request of 1..MAX_BEATS bus-width beats (8/16/24/32-bit operands for 65832 mode) into sequential strobe/ready handshakes.
- Assembles read data little-endian, steers write data by byte lane, and aborts with an error when memory never answers within TIMEOUT cycles.

---
 rtl/cpu_bus_pkg.sv | 16 +
 rtl/cpu_bus_lane_mux.sv | 17 +
 rtl/cpu_bus_master.sv | 136 +++++++++++++
 tb/tb_cpu_bus_master.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared state encoding, operand-size codes and default widths
// for the CPU-to-memory bus interface unit.
package cpu_bus_pkg;
   localparam int ADDR_W_DEF    = 32;
   localparam int BUS_W_DEF     = 8;
   localparam int MAX_BEATS_DEF = 4;
   localparam int DATA_W_DEF    = BUS_W_DEF * MAX_BEATS_DEF;
   localparam int TIMEOUT_DEF   = 255;

   localparam logic [1:0] SZ_8  = 2'd0;
   localparam logic [1:0] SZ_16 = 2'd1;
   localparam logic [1:0] SZ_24 = 2'd2;
   localparam logic [1:0] SZ_32 = 2'd3;

   typedef enum logic [1:0] {IDLE, STROBE, RELEASE, DONE} bus_state_e;
endpackage

// File: rtl/cpu_bus_lane_mux.sv
// cpu_bus_lane_mux: picks the write byte lane for a beat and decodes which
// read lane captures the incoming beat.
module cpu_bus_lane_mux #(
   parameter int BUS_W     = 8,
   parameter int MAX_BEATS = 4,
   parameter int SW        = $clog2(MAX_BEATS)
) (
   input  logic [MAX_BEATS*BUS_W-1:0] wdata_i,
   input  logic [SW-1:0]              wsel_i,
   input  logic [SW-1:0]              rsel_i,
   input  logic                       rd_en_i,
   output logic [BUS_W-1:0]           lane_o,
   output logic [MAX_BEATS-1:0]       lane_we_o
);
   assign lane_o    = wdata_i[wsel_i*BUS_W +: BUS_W];
   assign lane_we_o = rd_en_i ? MAX_BEATS'(1) << rsel_i : '0;
endmodule

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: splits a CPU request into 1..MAX_BEATS strobe/ready bus
// handshakes, assembling read data little-endian and aborting on timeout.
import cpu_bus_pkg::*;
module cpu_bus_master #(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BUS_W     = BUS_W_DEF,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req,
   input  logic                         i_we,
   input  logic [ADDR_W-1:0]            i_addr,
   input  logic [DATA_W-1:0]            i_wdata,
   input  logic [$clog2(MAX_BEATS)-1:0] i_size,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_err,
   output logic [DATA_W-1:0]            o_rdata,
   output logic                         o_bus_clk,
   output logic                         o_bus_we,
   output logic [ADDR_W-1:0]            o_bus_addr,
   output logic [BUS_W-1:0]             o_bus_data,
   input  logic [BUS_W-1:0]             i_bus_data,
   input  logic                         i_bus_data_ready
);
   localparam int SW = $clog2(MAX_BEATS);
   localparam int TW = $clog2(TIMEOUT + 2);

   bus_state_e           state_q;
   logic                 start_q, we_q, busy_q, done_q, err_q, bclk_q, bwe_q;
   logic [SW-1:0]        beat_q, beat_d, size_q, wsel;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, rdata_q;
   logic [BUS_W-1:0]     bdata_q, lane;
   logic [MAX_BEATS-1:0] lane_we;

   assign beat_d = beat_q + SW'(1);
   assign addr_d = addr_q + ADDR_W'(1);
   assign tmo_d  = tmo_q + TW'(1);
   // Leaving RELEASE presents the next beat's lane; otherwise the current one.
   assign wsel   = state_q == RELEASE ? beat_d : beat_q;

   cpu_bus_lane_mux #(.BUS_W(BUS_W), .MAX_BEATS(MAX_BEATS)) u_lane (
      .wdata_i   (wdata_q),
      .wsel_i    (wsel),
      .rsel_i    (beat_q),
      .rd_en_i   (state_q == STROBE && i_bus_data_ready && !we_q),
      .lane_o    (lane),
      .lane_we_o (lane_we)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         {start_q, we_q, busy_q, done_q, err_q, bclk_q, bwe_q} <= '0;
         beat_q  <= '0;
         size_q  <= '0;
         tmo_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         bdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE:
               if (start_q) begin
                  start_q <= 1'b0;
                  bclk_q  <= 1'b1;
                  bwe_q   <= we_q;
                  bdata_q <= lane;
                  state_q <= STROBE;
               end else if (i_req) begin
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  we_q    <= i_we;
                  addr_q  <= i_addr;
                  wdata_q <= i_wdata;
                  size_q  <= i_size;
                  rdata_q <= '0;
                  beat_q  <= '0;
                  tmo_q   <= '0;
               end
            STROBE:
               if (i_bus_data_ready) begin
                  for (int k = 0; k < MAX_BEATS; k++)
                     if (lane_we[k]) rdata_q[k*BUS_W +: BUS_W] <= i_bus_data;
                  bclk_q  <= 1'b0;
                  bwe_q   <= 1'b0;
                  state_q <= RELEASE;
               end else begin
                  tmo_q <= tmo_d;
                  if (TIMEOUT != 0 && tmo_d == TW'(TIMEOUT)) begin
                     bclk_q  <= 1'b0;
                     bwe_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end
               end
            RELEASE:
               if (!i_bus_data_ready) begin
                  if (beat_q == size_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     beat_q  <= beat_d;
                     addr_q  <= addr_d;
                     bclk_q  <= 1'b1;
                     bwe_q   <= we_q;
                     bdata_q <= lane;
                     tmo_q   <= '0;
                     state_q <= STROBE;
                  end
               end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_rdata    = rdata_q;
   assign o_bus_clk  = bclk_q;
   assign o_bus_we   = bwe_q;
   assign o_bus_addr = addr_q;
   assign o_bus_data = bdata_q;
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: directed vectors against a zero-wait byte memory model
// with hand-computed strobes, read data, latency, timeout and reset cases.
module tb_cpu_bus_master;
   import cpu_bus_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [1:0]  size = '0;
   logic        busy, done, err, bclk, bwe, rdy;
   logic [31:0] rdata, baddr;
   logic [7:0]  bdata, bdin;
   logic        mem_on = 1'b1;
   logic [7:0]  lut [4];
   logic [40:0] strb [$];
   logic        bclk_prev = 1'b0;
   logic        busy_seen, err_seen;
   logic [31:0] rd_seen;
   int          checks = 0, errors = 0;
   int          lat, hi, base, cnt;
   logic        saw_done;

   cpu_bus_master dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .i_size(size), .o_busy(busy), .o_done(done),
      .o_err(err), .o_rdata(rdata), .o_bus_clk(bclk), .o_bus_we(bwe),
      .o_bus_addr(baddr), .o_bus_data(bdata), .i_bus_data(bdin),
      .i_bus_data_ready(rdy)
   );

   always #5 clk = ~clk;

   assign rdy  = bclk & mem_on;
   assign bdin = lut[baddr[1:0]];

   always @(negedge clk) begin
      if (bclk && !bclk_prev) strb.push_back({bwe, baddr, bdata});
      bclk_prev <= bclk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      @(negedge clk);
      we = w; addr = a; wdata = d; size = s; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      busy_seen = busy;
      lat = 0; hi = 0;
      while (!done && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (bclk) hi++;
      end
      err_seen = err;
      rd_seen  = rdata;
      @(posedge clk); #1;
   endtask

   initial begin
      lut = '{8'h00, 8'h00, 8'h00, 8'h00};
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {busy, done, err, bclk, bwe, rdata, baddr, bdata}, '0);
      @(negedge clk); rst = 1'b0;

      lut[0] = 8'hA5;
      base = strb.size();
      run(1'b0, 32'h1234, 32'h0, SZ_8);
      check("rd1_lat", lat, 3);
      check("rd1_data", rd_seen, 32'h0000_00A5);
      check("rd1_err", err_seen, 0);
      check("rd1_busy", busy_seen, 1);
      check("rd1_nstrb", strb.size() - base, 1);
      check("rd1_addr", strb[base][39:8], 32'h1234);
      check("done_pulse", done, 0);

      lut = '{8'h11, 8'h22, 8'h33, 8'h44};
      base = strb.size();
      run(1'b0, 32'h2000, 32'h0, SZ_32);
      check("rd4_lat", lat, 9);
      check("rd4_data", rd_seen, 32'h4433_2211);
      check("rd4_nstrb", strb.size() - base, 4);
      check("rd4_a0", strb[base][39:8], 32'h2000);
      check("rd4_a3", strb[base+3][39:8], 32'h2003);

      base = strb.size();
      run(1'b1, 32'h3000, 32'hDEAD_BEEF, SZ_16);
      check("wr2_lat", lat, 5);
      check("wr2_nstrb", strb.size() - base, 2);
      check("wr2_b0", strb[base], {1'b1, 32'h3000, 8'hEF});
      check("wr2_b1", strb[base+1], {1'b1, 32'h3001, 8'hBE});
      check("wr2_rdata", rd_seen, 32'h0);

      mem_on = 1'b0;
      base = strb.size();
      run(1'b0, 32'h4000, 32'h0, SZ_8);
      check("tmo_lat", lat, 256);
      check("tmo_hi", hi, 255);
      check("tmo_err", err_seen, 1);
      check("tmo_nstrb", strb.size() - base, 1);
      mem_on = 1'b1;
      lut = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run(1'b0, 32'h1234, 32'h0, SZ_8);
      check("post_tmo_data", rd_seen, 32'h0000_00A5);
      check("post_tmo_err", err_seen, 0);

      lut = '{8'hC3, 8'h00, 8'h00, 8'h5A};
      base = strb.size();
      run(1'b0, 32'hFFFF_FFFF, 32'h0, SZ_16);
      check("wrap_a1", strb[base+1][39:8], 32'h0);
      check("wrap_data", rd_seen, 32'h0000_C35A);

      lut = '{8'h11, 8'h22, 8'h33, 8'h44};
      @(negedge clk);
      we = 1'b0; addr = 32'h2000; size = SZ_32; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      cnt = 0;
      while (!(bclk && baddr == 32'h2002) && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("rst_reach_beat2", cnt < 100, 1);
      rst = 1'b1;
      #1;
      check("rst_bclk", bclk, 0);
      check("rst_busy", busy, 0);
      saw_done = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("rst_no_done", saw_done, 0);
      rst = 1'b0;
      base = strb.size();
      run(1'b1, 32'h5000, 32'h0102_0304, SZ_32);
      check("post_rst_lat", lat, 9);
      check("post_rst_nstrb", strb.size() - base, 4);
      check("post_rst_b3", strb[base+3], {1'b1, 32'h5003, 8'h01});
      check("post_rst_err", err_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
